// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART frame decoder: header bytes, FSM state
// codes, payload field layout, default command words and GA-to-slot mapping.
package uart_frame_decoder_pkg;

   localparam logic [7:0] HDR0 = 8'hEB;
   localparam logic [7:0] HDR1 = 8'h9C;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_HEAD2    = 3'd1;
   localparam state_t ST_PAYLOAD  = 3'd2;
   localparam state_t ST_CSUM     = 3'd3;
   localparam state_t ST_DISPATCH = 3'd4;

   localparam int CMD_LSB  = 32;
   localparam int SLOT_LSB = 28;
   localparam int PORT_LSB = 24;
   localparam int DATA_LSB = 0;

   localparam logic [31:0] DEF_WR_CMD  = 32'h02002000;
   localparam logic [31:0] DEF_CLR_CMD = 32'h02002004;
   localparam logic [3:0]  PORT_ALL    = 4'hF;

   typedef struct packed {
      logic [31:0] cmd;
      logic [3:0]  slot;
      logic [3:0]  port;
      logic [23:0] data;
   } payload_t;

   // Backplane geographic address to slot number; unpopulated positions map to 0.
   function automatic logic [3:0] ga_to_slot(input logic [4:0] ga);
      if (ga >= 5'd2 && ga <= 5'd8)
         return ga[3:0] - 4'd1;
      else if (ga >= 5'd10 && ga <= 5'd17)
         return 4'(ga - 5'd2);
      else
         return 4'd0;
   endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and RAM write bus of the UART frame decoder.
interface uart_frame_decoder_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 24
);
   logic [7:0]           frame_data_in;
   logic                 frame_data_ena;
   logic [NUM_PORTS-1:0] o_wea;
   logic [ADDR_W-1:0]    o_waddr;
   logic [DATA_W-1:0]    o_wdata;

   modport master (output frame_data_in, frame_data_ena,
                   input  o_wea, o_waddr, o_wdata);
   modport slave  (input  frame_data_in, frame_data_ena,
                   output o_wea, o_waddr, o_wdata);
endinterface

// File: rtl/uart_frame_addr_ctr.sv
// Per-port RAM write-address counter with sticky wrap flag.
module uart_frame_addr_ctr
   import uart_frame_decoder_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic              clr,
   output logic [ADDR_W-1:0] addr,
   output logic              ovf
);
   // Advance after each write; flag the wrap from all-ones back to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         addr <= '0;
         ovf  <= 1'b0;
      end else if (wr) begin
         addr <= addr + ADDR_W'(1);
         if (addr == '1)
            ovf <= 1'b1;
      end
   end
endmodule

// File: rtl/uart_frame_decoder.sv
// UART command-frame decoder: parses EB 9C framed packets, validates the
// checksum and slot, and turns write/clear commands into RAM port strobes.
module uart_frame_decoder
   import uart_frame_decoder_pkg::*;
#(
   parameter int          NUM_PORTS   = 4,
   parameter int          ADDR_W      = 11,
   parameter int          DATA_W      = 24,
   parameter int          TIMEOUT_CYC = 1000,
   parameter logic [31:0] WR_CMD      = DEF_WR_CMD,
   parameter logic [31:0] CLR_CMD     = DEF_CLR_CMD
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_frame_decoder_if.slave  bus,
   input  logic [4:0]           GA,
   output logic [NUM_PORTS-1:0] o_ovf,
   output logic [15:0]          o_ok_cnt,
   output logic [15:0]          o_csum_err_cnt,
   output logic [15:0]          o_to_err_cnt
);
   localparam int               GAP_W      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [4:0]       PORT_LIMIT = 5'(NUM_PORTS);

   state_t            state;
   logic [2:0]        idx;
   logic [63:0]       payload;
   logic [7:0]        csum;
   logic [GAP_W-1:0]  gap;
   logic [3:0]        slot_q;
   logic              in_frame, timeout, csum_ok;
   payload_t          pl;

   logic              vld_p1, wr_p1, clr_p1;
   logic [3:0]        port_p1;
   logic [DATA_W-1:0] data_p1;

   logic [NUM_PORTS-1:0] ctr_wr, ctr_clr;
   logic [ADDR_W-1:0]    ctr_addr [NUM_PORTS];
   logic [ADDR_W-1:0]    sel_addr;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Frame status flags and payload field split.
   always_comb begin
      in_frame = (state == ST_HEAD2) || (state == ST_PAYLOAD) || (state == ST_CSUM);
      timeout  = in_frame && !bus.frame_data_ena && (gap == GAP_LAST);
      csum_ok  = (csum == 8'h00);
      pl.cmd   = payload[CMD_LSB +: 32];
      pl.slot  = payload[SLOT_LSB +: 4];
      pl.port  = payload[PORT_LSB +: 4];
      pl.data  = payload[DATA_LSB +: 24];
   end

   // Byte parser: header sync, payload capture, running checksum, gap timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         payload <= '0;
         csum    <= '0;
         gap     <= '0;
      end else if (timeout) begin
         state <= ST_IDLE;
         gap   <= '0;
      end else if (in_frame && !bus.frame_data_ena) begin
         gap <= gap + GAP_W'(1);
      end else begin
         gap <= '0;
         case (state)
            ST_HEAD2: begin
               if (bus.frame_data_in == HDR1) begin
                  state <= ST_PAYLOAD;
                  idx   <= '0;
                  csum  <= csum + bus.frame_data_in;
               end else if (bus.frame_data_in == HDR0) begin
                  csum <= HDR0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_PAYLOAD: begin
               payload[{idx, 3'b000} +: 8] <= bus.frame_data_in;
               csum <= csum + bus.frame_data_in;
               if (idx == 3'd7)
                  state <= ST_CSUM;
               else
                  idx <= idx + 3'd1;
            end
            ST_CSUM: begin
               csum  <= csum + bus.frame_data_in;
               state <= ST_DISPATCH;
            end
            default: begin
               // IDLE and the single DISPATCH cycle both look for a new header.
               state <= ST_IDLE;
               if (bus.frame_data_ena && bus.frame_data_in == HDR0) begin
                  state <= ST_HEAD2;
                  csum  <= HDR0;
               end
            end
         endcase
      end
   end

   // Slot number derived from the geographic address, registered every cycle.
   always_ff @(posedge clk) begin
      if (rst)
         slot_q <= '0;
      else
         slot_q <= ga_to_slot(GA);
   end

   // Frame statistics, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_ok_cnt       <= '0;
         o_csum_err_cnt <= '0;
         o_to_err_cnt   <= '0;
      end else begin
         if (timeout)
            o_to_err_cnt <= sat_inc(o_to_err_cnt);
         if (state == ST_DISPATCH) begin
            if (csum_ok)
               o_ok_cnt <= sat_inc(o_ok_cnt);
            else
               o_csum_err_cnt <= sat_inc(o_csum_err_cnt);
         end
      end
   end

   // Stage p1 control: a valid, slot-matched frame qualifies a write or clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         wr_p1  <= 1'b0;
         clr_p1 <= 1'b0;
      end else begin
         vld_p1 <= (state == ST_DISPATCH) && csum_ok && (pl.slot == slot_q);
         wr_p1  <= (pl.cmd == WR_CMD) && ({1'b0, pl.port} < PORT_LIMIT);
         clr_p1 <= (pl.cmd == CLR_CMD);
      end
   end

   // Stage p1 data: port and write data carried with the control bits.
   always_ff @(posedge clk) begin
      port_p1 <= pl.port;
      data_p1 <= pl.data[DATA_W-1:0];
   end

   // Per-port write/clear strobes and selection of the addressed counter.
   always_comb begin
      ctr_wr   = '0;
      ctr_clr  = '0;
      sel_addr = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         ctr_wr[i]  = vld_p1 && wr_p1 && (port_p1 == 4'(i));
         ctr_clr[i] = vld_p1 && clr_p1 && ((port_p1 == 4'(i)) || (port_p1 == PORT_ALL));
         if (port_p1 == 4'(i))
            sel_addr = ctr_addr[i];
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      uart_frame_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
         .clk  (clk),
         .rst  (rst),
         .wr   (ctr_wr[p]),
         .clr  (ctr_clr[p]),
         .addr (ctr_addr[p]),
         .ovf  (o_ovf[p])
      );
   end

   // Stage p2: one-cycle write strobe; address and data hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o_wea   <= '0;
         bus.o_waddr <= '0;
         bus.o_wdata <= '0;
      end else begin
         bus.o_wea <= ctr_wr;
         if (|ctr_wr) begin
            bus.o_waddr <= sel_addr;
            bus.o_wdata <= data_p1;
         end
      end
   end

endmodule
